// File: rtl/mdc_fsm.sv
// ---------------------------------------------------------------------------
// mdc_fsm -- greatest common divisor by repeated subtraction
//
// Purpose:
//   Computes gcd(i_a, i_b) for two W-bit unsigned operands using the
//   subtractive Euclid method, one compare/subtract step per clock.
//   A load (ld) is accepted in every state and always restarts the
//   computation.
//
// Handshake (one rule for the whole block):
//   ld is a single-cycle request with no back-pressure. Any cycle in which
//   ld=1 (and rst=0) captures i_a/i_b, clears done, sets busy and discards
//   whatever was in flight. done=1 means res holds a valid gcd, and it stays
//   valid until the next ld or rst. busy and done are never both high.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset, has priority over ld
//   ld         in   1   start a new computation on i_a, i_b
//   i_a        in   W   first operand, sampled only when ld=1
//   i_b        in   W   second operand, sampled only when ld=1
//   res        out  W   gcd result, registered
//   done       out  1   res is valid, registered
//   busy       out  1   computation in progress, registered
//   state_dbg  out  2   current FSM state (0=IDLE, 1=RUN, 2=FIN)
//   cnt        out  W   subtraction steps of the last computation
//                       (present only when MDC_CNT_EN is defined)
//
// Configuration:
//   MDC_CNT_EN  define to add the saturating step counter and the cnt port.
// ---------------------------------------------------------------------------
module mdc_fsm #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] res,
    output logic         done,
    output logic         busy,
    output logic [1:0]   state_dbg
`ifdef MDC_CNT_EN
    ,
    output logic [W-1:0] cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] res_q;
    logic         done_q;
    logic         busy_q;

`ifdef MDC_CNT_EN
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MDC_CNT_EN
            cnt_q   <= '0;
`endif
        end else if (ld) begin
            // A load wins in every state: any in-flight or finished result is
            // dropped and the new operands start from scratch.
            state_q <= S_RUN;
            a_q     <= i_a;
            b_q     <= i_b;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef MDC_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (a_q == '0) begin
                        res_q   <= b_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else if (b_q == '0) begin
                        res_q   <= a_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else if (a_q == b_q) begin
                        // Equality ends the run one subtraction early, which
                        // is why latency is steps + 1 rather than steps + 2.
                        res_q   <= a_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else if (a_q > b_q) begin
                        // Larger minus smaller, so no underflow is possible.
                        a_q     <= a_q - b_q;
`ifdef MDC_CNT_EN
                        cnt_q   <= cnt_d;
`endif
                    end else begin
                        b_q     <= b_q - a_q;
`ifdef MDC_CNT_EN
                        cnt_q   <= cnt_d;
`endif
                    end
                end
                S_FIN: begin
                    // Result and flags hold until the next ld or rst.
                    state_q <= S_FIN;
                end
                default: begin
                    // IDLE (and any unused encoding) holds all outputs.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign res       = res_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
`ifdef MDC_CNT_EN
    assign cnt       = cnt_q;
`endif

endmodule

// File: tb/tb_mdc_fsm.sv
// ---------------------------------------------------------------------------
// tb_mdc_fsm -- self-checking bench for mdc_fsm
//
// Directed vectors come from a table of hand-computed results; random
// operand pairs are checked against a Euclid-by-division model that derives
// the gcd and the number of subtraction steps arithmetically.
// ---------------------------------------------------------------------------
module tb_mdc_fsm;

    localparam int W   = 16;
    localparam int LIM = 2000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld  = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic [W-1:0] res;
    logic         done;
    logic         busy;
    logic [1:0]   state_dbg;
`ifdef MDC_CNT_EN
    logic [W-1:0] cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    mdc_fsm #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .i_a       (i_a),
        .i_b       (i_b),
        .res       (res),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef MDC_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: division-based Euclid. Each quotient counts that many
    // subtractions; when both operands start nonzero, the final subtraction
    // that would reach zero is replaced by the equality exit.
    task automatic model(input int a, input int b, output int g, output int steps);
        int x = a;
        int y = b;
        steps = 0;
        while (x != 0 && y != 0) begin
            if (x >= y) begin
                steps += x / y;
                x = x % y;
            end else begin
                steps += y / x;
                y = y % x;
            end
        end
        g = (x != 0) ? x : y;
        if (a != 0 && b != 0) steps -= 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Pulse ld for one edge; returns just after that edge.
    task automatic do_ld(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        ld  = 1'b1;
        i_a = a;
        i_b = b;
        @(posedge clk);
        #1;
        ld  = 1'b0;
        i_a = $urandom_range(0, 65535);   // must be ignored from here on
        i_b = $urandom_range(0, 65535);
    endtask

    // Load, wait for done, compare result/latency/count, then check hold.
    task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_res, input int exp_lat, input int exp_cnt);
        int   n = 0;
        logic busy_bad = 1'b0;
        logic [W-1:0] held;
        exp_q.push_back(exp_res[W-1:0]);
        do_ld(a, b);
        check({name, " start_flags"}, {30'd0, busy, done}, 32'd2);
        while (done !== 1'b1 && n < LIM) begin
            @(posedge clk);
            #1;
            n++;
            if (done !== 1'b1 && busy !== 1'b1) busy_bad = 1'b1;
        end
        if (n >= LIM) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, n);
        end
        check({name, " busy_during_run"}, {31'd0, busy_bad}, 32'd0);
        check({name, " latency"}, n, exp_lat);
        check({name, " res"}, res, exp_q.pop_front());
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef MDC_CNT_EN
        check({name, " cnt"}, cnt, exp_cnt);
`endif
        held = res;
        repeat (3) @(posedge clk);
        #1;
        check({name, " hold"}, {14'd0, state_dbg, done, res}, {14'd0, 2'd2, 1'b1, held});
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           res;
        int           lat;
        int           cnt;
    } vec_t;

    // ---------------- test ----------------
    initial begin : main
        vec_t vecs[7];
        int   g;
        int   steps;
        int   n;
        logic saw_done;

        vecs[0] = '{"v12_8",   16'd12, 16'd8,   4, 3,   2};
        vecs[1] = '{"v1_100",  16'd1,  16'd100, 1, 100, 99};
        vecs[2] = '{"v0_5",    16'd0,  16'd5,   5, 1,   0};
        vecs[3] = '{"v0_0",    16'd0,  16'd0,   0, 1,   0};
        vecs[4] = '{"v5_0",    16'd5,  16'd0,   5, 1,   0};
        vecs[5] = '{"v9_9",    16'd9,  16'd9,   9, 1,   0};
        vecs[6] = '{"v21_14",  16'd21, 16'd14,  7, 3,   2};

        // Reset for two cycles, then idle with no ld must hold zeros.
        do_reset(2);
        check("reset_outputs", {13'd0, state_dbg, busy, done, res}, 32'd0);
`ifdef MDC_CNT_EN
        check("reset_cnt", cnt, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", {13'd0, state_dbg, busy, done, res}, 32'd0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].cnt);
        end

        // Restart: ld 1,100 then ld 21,14 ten cycles later.
        do_ld(16'd1, 16'd100);
        saw_done = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("restart_no_early_done", {31'd0, saw_done}, 32'd0);
        run("restart_21_14", 16'd21, 16'd14, 7, 3, 2);

        // Reset mid-run: everything clears, nothing ever flagged.
        do_ld(16'd1, 16'd100);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ld  = 1'b1;           // rst must win over ld
        i_a = 16'd3;
        i_b = 16'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ld  = 1'b0;
        check("midrun_rst", {13'd0, state_dbg, busy, done, res}, 32'd0);
`ifdef MDC_CNT_EN
        check("midrun_rst_cnt", cnt, 32'd0);
`endif
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("after_rst_quiet", {31'd0, saw_done}, 32'd0);
        run("post_rst_9_9", 16'd9, 16'd9, 9, 1, 0);

        // Random pairs against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 300));
            rb = W'($urandom_range(0, 300));
            if (i % 8 == 3) ra = '0;
            model(int'(ra), int'(rb), g, steps);
            run($sformatf("rnd%0d_%0d_%0d", i, ra, rb), ra, rb, g, steps + 1, steps);
        end

        // Back-to-back loads on consecutive edges: only the last one counts.
        do_ld(16'd100, 16'd1);
        n = 0;
        run("b2b_48_36", 16'd48, 16'd36, 12, 4, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
